status_blink_coder: RTL and testbench

- Downstream consumer of the heartbeat square wave; drives the board status LED.
- With no status pending, the LED mirrors the heartbeat.
- With a nonzero status code, the LED blinks the code as N short flashes followed by a long dark gap, timed in heartbeat ticks.
- Lets the SDR front end report simple fault and mode codes (PLL unlock, ADC overrange, ...) on the same LED without a second timebase.

---
 rtl/status_pkg.sv | 16 +
 rtl/beat_edge_detect.sv | 22 ++
 rtl/status_blink_coder.sv | 129 ++++++++++++
 tb/tb_status_blink_coder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/status_pkg.sv
// Shared types and status code constants for the status LED blink coder.
package status_pkg;

  typedef enum logic [1:0] {
    HB  = 2'd0,
    ON  = 2'd1,
    OFF = 2'd2,
    GAP = 2'd3
  } state_e;

  localparam logic [3:0] ST_OK         = 4'd0;
  localparam logic [3:0] ST_PLL_UNLOCK = 4'd1;
  localparam logic [3:0] ST_ADC_OVR    = 4'd2;
  localparam logic [3:0] ST_FIFO_ERR   = 4'd3;

endpackage

// File: rtl/beat_edge_detect.sv
// Turns the heartbeat square wave into a one-cycle tick on each of its edges.
module beat_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic beat_in,
  output logic tick
);

  logic beat_q_r;

  // Delayed copy of the heartbeat; resets low so a high beat right after reset is a tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q_r <= 1'b0;
    end else begin
      beat_q_r <= beat_in;
    end
  end

  assign tick = beat_in ^ beat_q_r;

endmodule

// File: rtl/status_blink_coder.sv
// Status LED driver: mirrors the heartbeat when healthy, otherwise blinks the
// status code as N short flashes plus a long dark gap, timed in heartbeat ticks.
module status_blink_coder
  import status_pkg::*;
#(
  parameter int CODE_W     = 4,
  parameter int ON_TICKS   = 1,
  parameter int OFF_TICKS  = 1,
  parameter int GAP_TICKS  = 4,
  parameter int TICK_CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              beat_in,
  input  logic [CODE_W-1:0] status_code,
  output logic              led_out,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [TICK_CNT_W-1:0] ON_LAST  = TICK_CNT_W'(ON_TICKS - 1);
  localparam logic [TICK_CNT_W-1:0] OFF_LAST = TICK_CNT_W'(OFF_TICKS - 1);
  localparam logic [TICK_CNT_W-1:0] GAP_LAST = TICK_CNT_W'(GAP_TICKS - 1);
  localparam logic [TICK_CNT_W-1:0] CNT_ZERO = {TICK_CNT_W{1'b0}};
  localparam logic [CODE_W-1:0]     CODE_ZERO = {CODE_W{1'b0}};

  logic                  tick_s;
  state_e                state_r;
  logic [TICK_CNT_W-1:0] tick_cnt_r;
  logic [CODE_W-1:0]     blink_cnt_r;
  logic [CODE_W-1:0]     code_r;
  logic                  led_out_r;
  logic                  busy_r;
  logic                  frame_done_r;

  beat_edge_detect u_beat_edge_detect (
    .clk     (clk),
    .rst     (rst),
    .beat_in (beat_in),
    .tick    (tick_s)
  );

  // Blink frame sequencer; without ticks every branch holds, freezing the LED.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= HB;
      tick_cnt_r   <= CNT_ZERO;
      blink_cnt_r  <= CODE_ZERO;
      code_r       <= CODE_ZERO;
      led_out_r    <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      case (state_r)
        HB: begin
          led_out_r <= beat_in;
          if (tick_s && (status_code != CODE_ZERO)) begin
            code_r      <= status_code;
            blink_cnt_r <= CODE_ZERO;
            tick_cnt_r  <= CNT_ZERO;
            led_out_r   <= 1'b1;
            busy_r      <= 1'b1;
            state_r     <= ON;
          end
        end
        ON: begin
          if (tick_s) begin
            if (tick_cnt_r == ON_LAST) begin
              tick_cnt_r  <= CNT_ZERO;
              blink_cnt_r <= blink_cnt_r + CODE_W'(1);
              led_out_r   <= 1'b0;
              state_r     <= OFF;
            end else begin
              tick_cnt_r <= tick_cnt_r + TICK_CNT_W'(1);
            end
          end
        end
        OFF: begin
          if (tick_s) begin
            if (tick_cnt_r == OFF_LAST) begin
              tick_cnt_r <= CNT_ZERO;
              if (blink_cnt_r == code_r) begin
                state_r <= GAP;
              end else begin
                led_out_r <= 1'b1;
                state_r   <= ON;
              end
            end else begin
              tick_cnt_r <= tick_cnt_r + TICK_CNT_W'(1);
            end
          end
        end
        GAP: begin
          if (tick_s) begin
            if (tick_cnt_r == GAP_LAST) begin
              frame_done_r <= 1'b1;
              tick_cnt_r   <= CNT_ZERO;
              // The next code is only ever sampled here, so mid-frame changes wait.
              if (status_code == CODE_ZERO) begin
                led_out_r <= beat_in;
                busy_r    <= 1'b0;
                state_r   <= HB;
              end else begin
                code_r      <= status_code;
                blink_cnt_r <= CODE_ZERO;
                led_out_r   <= 1'b1;
                state_r     <= ON;
              end
            end else begin
              tick_cnt_r <= tick_cnt_r + TICK_CNT_W'(1);
            end
          end
        end
        default: begin
          state_r    <= HB;
          tick_cnt_r <= CNT_ZERO;
          led_out_r  <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  assign led_out    = led_out_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_status_blink_coder.sv
// Scoreboard bench for status_blink_coder: a frame-level model predicts led/busy/done each cycle.
module tb_status_blink_coder;
  import status_pkg::*;

  localparam int CODE_W    = 4;
  localparam int ON_TICKS  = 1;
  localparam int OFF_TICKS = 1;
  localparam int GAP_TICKS = 4;
  localparam int HALF      = 10;

  typedef struct packed {
    logic led;
    logic busy;
    logic done;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              beat_in = 1'b0;
  logic [CODE_W-1:0] status_code = '0;
  logic              led_out;
  logic              busy;
  logic              frame_done;

  exp_t sb_q[$];
  logic plan_q[$];
  int   done_q[$];

  logic beat_prev = 1'b0;
  logic in_frame  = 1'b0;
  logic exp_led   = 1'b0;
  logic exp_busy  = 1'b0;
  logic exp_done  = 1'b0;
  logic beat_v    = 1'b0;
  logic freeze    = 1'b0;
  int   phase = 0;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  status_blink_coder #(
    .CODE_W    (CODE_W),
    .ON_TICKS  (ON_TICKS),
    .OFF_TICKS (OFF_TICKS),
    .GAP_TICKS (GAP_TICKS),
    .TICK_CNT_W(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .beat_in    (beat_in),
    .status_code(status_code),
    .led_out    (led_out),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    if (obs !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, expv, cyc);
    end
  endtask

  // Lay out the whole frame as one LED level per tick interval.
  task automatic start_frame(input logic [CODE_W-1:0] code);
    plan_q.delete();
    for (int b = 0; b < int'(code); b++) begin
      for (int i = 0; i < ON_TICKS; i++) plan_q.push_back(1'b1);
      for (int i = 0; i < OFF_TICKS; i++) plan_q.push_back(1'b0);
    end
    for (int i = 0; i < GAP_TICKS; i++) plan_q.push_back(1'b0);
    exp_led  = plan_q.pop_front();
    in_frame = 1'b1;
    exp_busy = 1'b1;
  endtask

  task automatic model(input logic r, input logic b, input logic [CODE_W-1:0] code);
    exp_t e;
    exp_done = 1'b0;
    if (r) begin
      in_frame = 1'b0;
      plan_q.delete();
      exp_led   = 1'b0;
      exp_busy  = 1'b0;
      beat_prev = 1'b0;
    end else begin
      if (b != beat_prev) begin
        if (in_frame && plan_q.size() == 0) begin
          exp_done = 1'b1;
          if (code != '0) start_frame(code);
          else begin
            in_frame = 1'b0;
            exp_busy = 1'b0;
            exp_led  = b;
          end
        end else if (in_frame) begin
          exp_led = plan_q.pop_front();
        end else if (code != '0) begin
          start_frame(code);
        end else begin
          exp_led = b;
        end
      end else if (!in_frame) begin
        exp_led = b;
      end
      beat_prev = b;
    end
    e = {exp_led, exp_busy, exp_done};
    sb_q.push_back(e);
  endtask

  task automatic cycle(input logic r, input logic [CODE_W-1:0] code);
    exp_t e;
    if (!freeze) begin
      phase++;
      if (phase == HALF) begin
        phase  = 0;
        beat_v = ~beat_v;
      end
    end
    rst         = r;
    beat_in     = beat_v;
    status_code = code;
    if (r) begin
      #1;
      chk("async_rst_led", led_out, 1'b0);
      chk("async_rst_busy", busy, 1'b0);
    end
    model(r, beat_v, code);
    @(posedge clk);
    #1;
    cyc++;
    e = sb_q.pop_front();
    chk("led", led_out, e.led);
    chk("busy", busy, e.busy);
    chk("frame_done", frame_done, e.done);
    if (frame_done) done_q.push_back(cyc);
  endtask

  task automatic run(input int n, input logic [CODE_W-1:0] code);
    for (int i = 0; i < n; i++) cycle(1'b0, code);
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_led", led_out, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", frame_done, 1'b0);

    // Healthy: LED mirrors heartbeat.
    run(60, ST_OK);
    chk("hb_no_done", done_q.size(), 0);

    // Code 3 applied between ticks, back-to-back frames of 10 ticks.
    run(3, ST_OK);
    done_q.delete();
    run(250, ST_FIFO_ERR);
    chk("frame3_cnt", done_q.size() >= 2, 1'b1);
    if (done_q.size() >= 2) chk("frame3_len", done_q[1] - done_q[0], 100);

    // 3 -> 0 during the second blink still completes the frame.
    run(200, ST_OK);
    guard = 0;
    while (guard < 100 && !(in_frame && plan_q.size() == 7)) begin
      cycle(1'b0, ST_FIFO_ERR);
      guard++;
    end
    chk("second_blink_reached", guard < 100, 1'b1);
    done_q.delete();
    run(200, ST_OK);
    chk("drop_to_ok_done_cnt", done_q.size(), 1);
    chk("drop_to_ok_idle", busy, 1'b0);

    // 2 -> 5 mid-frame: next frame is 14 ticks.
    done_q.delete();
    run(30, ST_ADC_OVR);
    run(300, 4'd5);
    chk("code5_cnt", done_q.size() >= 2, 1'b1);
    if (done_q.size() >= 2) chk("code5_len", done_q[1] - done_q[0], 140);
    run(200, ST_OK);

    // Reset during ON, then a 1-blink frame restarts.
    guard = 0;
    while (guard < 100 && !(in_frame && exp_led)) begin
      cycle(1'b0, ST_PLL_UNLOCK);
      guard++;
    end
    chk("on_reached", guard < 100, 1'b1);
    repeat (3) cycle(1'b1, ST_PLL_UNLOCK);
    done_q.delete();
    run(80, ST_PLL_UNLOCK);
    chk("post_rst_done", done_q.size() >= 1, 1'b1);
    run(100, ST_OK);

    // Heartbeat stalls while in OFF.
    guard = 0;
    while (guard < 100 && !(in_frame && !exp_led && plan_q.size() > GAP_TICKS)) begin
      cycle(1'b0, ST_FIFO_ERR);
      guard++;
    end
    chk("off_reached", guard < 100, 1'b1);
    freeze = 1'b1;
    run(1000, ST_FIFO_ERR);
    chk("stall_led", led_out, 1'b0);
    chk("stall_busy", busy, 1'b1);
    freeze = 1'b0;
    run(300, ST_FIFO_ERR);
    run(200, ST_OK);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
